// File: rtl/conv33_pkg.sv
// Shared constants for the conv33 serial weight-load interface.
package conv33_pkg;
  localparam int KERNEL_TAPS = 9;
  localparam int TAP_CNT_W   = 4;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] STREAM   = 2'd1;
  localparam logic [1:0] WAIT_ACK = 2'd2;
endpackage

// File: rtl/conv33_rd_pipe.sv
// Two-stage valid/data pipe: ROM read strobe -> data-valid -> start, ROM data -> data_out.
module conv33_rd_pipe #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  start,
  output logic [DATA_WIDTH-1:0] data_out
);
  logic [2:0] vld_pipe;

  assign vld_pipe[0] = rd_en;
  assign start       = vld_pipe[2];

  // vld_pipe[1] lines up with the sync-read ROM data, so it qualifies the capture
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[2:1] <= '0;
      data_out      <= '0;
    end else begin
      vld_pipe[2:1] <= vld_pipe[1:0];
      data_out      <= vld_pipe[1] ? rd_data : '0;
    end
  end
endmodule

// File: rtl/conv33_weight_sender.sv
// Streams the 9 taps of one kernel from the weight ROM to the conv33 loader and waits for its ack.
module conv33_weight_sender
  import conv33_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_W      = 10,
  parameter int KIDX_W      = 6,
  parameter int NUM_KERNELS = 64,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [KIDX_W-1:0]     kernel_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  start,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  weight_load
);
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

  logic [1:0]           state, nstate;
  logic [ADDR_W-1:0]    base, k_ext, base_d, addr_d;
  logic [TAP_CNT_W-1:0] tap_cnt, out_cnt;
  logic [TO_W-1:0]      to_cnt;
  logic                 accept, reject, issue, last_start, ack, tmo;
  logic                 busy_d, done_d, err_d, rd_en_d;

  // kernel_sel*9 as shift-and-add, truncated to the ROM address width
  assign k_ext  = ADDR_W'(kernel_sel);
  assign base_d = (k_ext << 3) + k_ext;

  assign accept     = (state == IDLE) && req && (32'(kernel_sel) < NUM_KERNELS);
  assign reject     = (state == IDLE) && req && !(32'(kernel_sel) < NUM_KERNELS);
  assign issue      = (state == STREAM) && (tap_cnt < TAP_CNT_W'(KERNEL_TAPS));
  assign last_start = (state == STREAM) && start && (out_cnt == TAP_CNT_W'(KERNEL_TAPS - 1));
  assign ack        = (state == WAIT_ACK) && weight_load;
  assign tmo        = (state == WAIT_ACK) && !weight_load && (to_cnt == TO_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      base    <= '0;
      tap_cnt <= '0;
      out_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      state <= nstate;
      // The first read is issued straight off the request, so the counter starts at 1
      if (accept) begin
        base    <= base_d;
        tap_cnt <= TAP_CNT_W'(1);
        out_cnt <= '0;
      end else begin
        if (issue) tap_cnt <= tap_cnt + 1'b1;
        if ((state == STREAM) && start) out_cnt <= out_cnt + 1'b1;
      end
      to_cnt <= (state == WAIT_ACK) ? to_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:     if (accept) nstate = STREAM;
      STREAM:   if (last_start) nstate = WAIT_ACK;
      WAIT_ACK: if (ack || tmo) nstate = IDLE;
      default:  nstate = IDLE;
    endcase
  end

  always_comb begin
    busy_d  = (nstate != IDLE);
    done_d  = ack;
    err_d   = reject || tmo;
    rd_en_d = accept || issue;
    addr_d  = '0;
    if (accept)     addr_d = base_d;
    else if (issue) addr_d = base + ADDR_W'(tap_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      mem_rd_en <= rd_en_d;
      mem_addr  <= addr_d;
    end
  end

  conv33_rd_pipe #(.DATA_WIDTH(DATA_WIDTH)) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (mem_rd_en),
    .rd_data  (mem_rd_data),
    .start    (start),
    .data_out (data_out)
  );
endmodule
